// File: rtl/rr_mux_reg_if.sv
// Handshake bundle for the registered arbitrating multiplexer.
// The producer-side channels and the consumer-side output share one interface.
// The arbiter itself is the slave; whoever drives the inputs and consumes the
// output is the master.
interface rr_mux_reg_if #(
  parameter int WIDTH = 32,
  parameter int N     = 4
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic [SW-1:0]      out_sel;

  modport slave (
    input  in_data,
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out_data,
    output out_valid,
    output out_sel
  );

  modport master (
    output in_data,
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out_data,
    input  out_valid,
    input  out_sel
  );
endinterface

// File: rtl/rr_mux_reg.sv
// Registered N-channel arbitrating multiplexer.
// One channel is chosen per cycle, either round-robin starting at r_ptr or by
// fixed priority with channel 0 highest. The winning word lands in a single
// output register that supports backpressure. Grant and in_ready are
// combinational. out_data, out_valid and out_sel come straight from flops.
module rr_mux_reg #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int RR    = 1
) (
  input  logic            clk,
  input  logic            rst,
  rr_mux_reg_if.slave     bus
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic [SW-1:0]    r_out_sel;
  logic [SW-1:0]    r_ptr;

  logic             w_load;
  logic             w_any;
  logic [SW-1:0]    w_grant;
  logic [N-1:0]     w_ready;
  logic [WIDTH-1:0] w_sel_data;
  logic             w_xfer;
  logic [SW-1:0]    w_ptr_next;

  // The register can take a new word when it is empty or being drained now.
  assign w_load = !r_out_valid || bus.out_ready;

  // Pick the winning channel. The first pass scans from r_ptr up to N-1, and
  // the second pass wraps around to channel 0. In fixed-priority mode the
  // first pass already covers every channel, so the lowest valid index wins.
  always_comb begin
    w_any   = 1'b0;
    w_grant = '0;
    for (int i = 0; i < N; i++) begin
      if (!w_any && bus.in_valid[i] && ((RR == 0) || (SW'(i) >= r_ptr))) begin
        w_any   = 1'b1;
        w_grant = SW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!w_any && bus.in_valid[i]) begin
        w_any   = 1'b1;
        w_grant = SW'(i);
      end
    end
  end

  // Only the granted channel sees ready, and only when the register can load.
  // Holding reset suppresses every ready bit so no word is accepted.
  always_comb begin
    w_ready = '0;
    for (int i = 0; i < N; i++) begin
      w_ready[i] = !rst && w_any && w_load && (w_grant == SW'(i));
    end
  end

  // Steer the granted channel's word towards the output register.
  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant == SW'(i)) begin
        w_sel_data = bus.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_xfer     = w_any && w_load;
  // Explicit wrap keeps the pointer in range when N is not a power of two.
  assign w_ptr_next = (w_grant == SW'(N - 1)) ? '0 : w_grant + SW'(1);

  // Output register and round-robin pointer. A load takes precedence over a
  // drain, so a simultaneous drain and load leaves out_valid high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_sel   <= '0;
      r_ptr       <= '0;
    end else if (w_xfer) begin
      r_out_data  <= w_sel_data;
      r_out_sel   <= w_grant;
      r_out_valid <= 1'b1;
      if (RR != 0) begin
        r_ptr <= w_ptr_next;
      end
    end else if (r_out_valid && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sel   = r_out_sel;
endmodule
